// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of the register file access port among NREQ requesters.
// Define REGFILE_ARB_CLEAR_EN to zero all 32 registers after every reset before the port opens.
module regfile_port_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [5*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rf_read_addr,
  output logic [4:0]        rf_write_addr,
  output logic              rf_r_or_w,
  output logic [31:0]       rf_wdata,
  input  logic [31:0]       rf_rdata,
  output logic              init_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NR = NREQ[PW:0];
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
  logic [PW-1:0] rr_ptr, gidx, off, p1_id, p2_id;
  logic [PW:0] sum;
  logic [NREQ-1:0] rot;
  logic hit, hs, g_we, rd, wr, p1_v, p1_z, p2_v, p2_z;
  logic [4:0] g_addr;
  logic [31:0] g_wdata;
`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [4:0] cnt;
  logic clr_last;
`endif
  // rotate so bit 0 is rr_ptr; the lowest set bit of rot is the grant offset
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) off = PW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    gidx = (sum >= NR) ? PW'(sum - NR) : PW'(sum);
  end
  assign hit = |req_valid;
  assign hs = init_done & hit;
  assign req_ready = hs ? (NREQ'(1) << gidx) : '0;
  assign g_we = req_we[gidx];
  assign g_addr = req_addr[5*gidx +: 5];
  assign g_wdata = req_wdata[32*gidx +: 32];
  assign rd = hs & ~g_we;
  assign wr = hs & g_we & (|g_addr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      p1_v <= 1'b0;
      p1_z <= 1'b0;
      p1_id <= '0;
      p2_v <= 1'b0;
      p2_z <= 1'b0;
      p2_id <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rf_r_or_w <= 1'b1;
      rf_read_addr <= '0;
      rf_write_addr <= '0;
      rf_wdata <= '0;
      init_done <= 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
      state <= CLEAR;
      cnt <= '0;
      clr_last <= 1'b0;
`endif
    end else begin
      p2_v <= p1_v;
      p2_z <= p1_z;
      p2_id <= p1_id;
      rsp_valid <= p2_v ? (NREQ'(1) << p2_id) : '0;
      if (p2_v) rsp_rdata <= p2_z ? '0 : rf_rdata;
      p1_v <= rd;
      p1_z <= ~|g_addr;
      p1_id <= gidx;
      rf_r_or_w <= ~wr;
      rf_read_addr <= rd ? g_addr : '0;
      rf_write_addr <= wr ? g_addr : '0;
      rf_wdata <= wr ? g_wdata : '0;
      if (hs) rr_ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
`ifdef REGFILE_ARB_CLEAR_EN
      if (state == CLEAR) begin
        rf_r_or_w <= clr_last;
        rf_read_addr <= '0;
        rf_write_addr <= clr_last ? 5'd0 : cnt;
        rf_wdata <= '0;
        cnt <= cnt + 5'd1;
        clr_last <= clr_last | (&cnt);
        if (clr_last) begin
          state <= RUN;
          init_done <= 1'b1;
        end
      end
`else
      init_done <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: scoreboard bench with a behavioural register file and reference model.
module tb_regfile_port_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_valid = '0, req_we = '0;
  logic [5*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_rdata, rf_wdata, rf_rdata = '0;
  logic [4:0] rf_read_addr, rf_write_addr;
  logic rf_r_or_w, init_done;
  logic [31:0] mem [32];
  logic [31:0] refm [32];
  typedef struct {int id; logic [31:0] data; int cyc;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, ptr = 0;

  regfile_port_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr), .rf_r_or_w(rf_r_or_w),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read register file: data appears after the edge that samples the read command
  always @(posedge clk)
    if (!rf_r_or_w) mem[rf_write_addr] <= rf_wdata;
    else rf_rdata <= mem[rf_read_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rsp_valid !== '0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc))) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_we[i] = w;
    req_addr[5*i +: 5] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
  endtask

  // one clock: check the grant against the model, then the command that appears on the rf port
  task automatic tick();
    int g;
    logic w;
    logic [4:0] a;
    logic [31:0] d;
    #3;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
    chk("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'(1 << g));
    if (g >= 0) begin
      w = req_we[g];
      a = req_addr[5*g +: 5];
      d = req_wdata[32*g +: 32];
      ptr = (g + 1) % N;
      if (!w) exp_q.push_back('{g, (a == 5'd0) ? 32'h0 : refm[a], cyc + 3});
      else if (a != 5'd0) refm[a] = d;
    end
    @(posedge clk);
    #1;
    if (g >= 0 && !w) chk("rf_read", 64'({rf_r_or_w, rf_read_addr}), 64'({1'b1, a}));
    else if (g >= 0 && a != 5'd0) chk("rf_write", 64'({rf_r_or_w, rf_write_addr, rf_wdata}), 64'({1'b0, a, d}));
    else chk("rf_idle", 64'({rf_r_or_w, rf_read_addr, rf_write_addr, rf_wdata}), 64'({1'b1, 5'd0, 5'd0, 32'd0}));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    ptr = 0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_init_done", 64'(init_done), 64'd0);
    chk("reset_rf_idle", 64'({rf_r_or_w, rf_read_addr, rf_write_addr, rf_wdata}), 64'({1'b1, 5'd0, 5'd0, 32'd0}));
    reset = 1'b0;
    #1;
    chk("init_before_edge", 64'(init_done), 64'd0);
`ifdef REGFILE_ARB_CLEAR_EN
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      chk("clear_write", 64'({rf_r_or_w, rf_write_addr, rf_wdata}), 64'({1'b0, 5'(k), 32'd0}));
      chk("clear_closed", 64'({init_done, req_ready}), 64'd0);
      refm[k] = 32'h0;
    end
`endif
    @(posedge clk);
    #1;
    chk("init_done", 64'(init_done), 64'd1);
    clear_reqs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      refm[i] = mem[i];
    end
    mem[0] = 32'hBAD0BAD0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 5'(i + 1), 32'h0);
    repeat (6) tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 5'd5, 32'h0);
    tick();
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 5'd0, 32'h12345678);
    tick();
    set_req(0, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    clear_reqs();
    repeat (3) tick();
    set_req(2, 1'b1, 1'b0, 5'd9, 32'h0);
    repeat (4) tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 5'(i + 10), 32'h0);
    repeat (3) tick();
    repeat (300) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 5'd7, 32'h0);
    tick();
    do_reset();
    repeat (4) tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    repeat (6) tick();
    clear_reqs();
    repeat (4) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
